// File: rtl/vmem_responder.sv
// ---------------------------------------------------------------------------
// vmem_responder
//
// Data-memory responder for the datapath's vector and scalar loads/stores.
// A word-addressed RAM serves bursts of 1..MAX_WORDS consecutive words, one
// word per clock. Load results land on five lanes (rd1..rd5) that line up
// with the five vector-ALU result lanes. While a burst is in flight ready is
// low, so the control unit can stall the datapath; completion is signalled
// by a one-cycle ack pulse, qualified by err when the request was rejected.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   req        in   request valid, sampled only while ready=1
//   we         in   1 = store burst, 0 = load burst
//   addr[31:0] in   byte address of word 0 (must be word aligned)
//   count[2:0] in   burst length in words, legal 1..MAX_WORDS
//   wd1..wd5   in   store data for words 0..4
//   ready      out  high only while idle
//   ack        out  one-cycle completion pulse
//   err        out  qualifies ack: the request was rejected
//   rd1..rd5   out  load data for words 0..4 (held until the next accept)
// ---------------------------------------------------------------------------
module vmem_responder #(
  parameter int unsigned DEPTH     = 64,
  // Tied to the number of vector lanes; the port list is sized for 5.
  parameter int unsigned MAX_WORDS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  count,
  input  logic [31:0] wd1,
  input  logic [31:0] wd2,
  input  logic [31:0] wd3,
  input  logic [31:0] wd4,
  input  logic [31:0] wd5,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3,
  output logic [31:0] rd4,
  output logic [31:0] rd5
);

  // Word-index width. The burst counter is 3 bits and is zero-extended into
  // the index, so DEPTH must be at least 16.
  localparam int unsigned AW = $clog2(DEPTH);

  // Range check runs one bit wider than the index so base+count-1 can't wrap.
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneW   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_d;
  logic          r_we;
  logic [AW-1:0] r_base;
  logic [2:0]    r_count;
  logic [2:0]    r_k;
  logic          r_err;
  logic [31:0]   r_wd [MAX_WORDS];
  logic [31:0]   r_rd [MAX_WORDS];
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_wd_in [MAX_WORDS];

  assign w_wd_in[0] = wd1;
  assign w_wd_in[1] = wd2;
  assign w_wd_in[2] = wd3;
  assign w_wd_in[3] = wd4;
  assign w_wd_in[4] = wd5;

  // -------------------------------------------------------------------------
  // Request legality, evaluated on the live request inputs at accept time
  // -------------------------------------------------------------------------
  logic          w_misalign;
  logic          w_count_bad;
  logic          w_hi_bad;
  logic          w_range_bad;
  logic          w_req_err;
  logic [AW:0]   w_end;

  always_comb begin
    w_misalign  = (addr[1:0] != 2'b00);
    w_count_bad = (count == 3'd0) || (32'(count) > MAX_WORDS);
    // Word-address bits above the RAM index must be zero; no aliasing.
    w_hi_bad    = |addr[31:AW+2];
    w_end       = {1'b0, addr[AW+1:2]} + {{(AW-2){1'b0}}, count} - OneW;
    w_range_bad = (w_end >= DepthW);
    w_req_err   = w_misalign | w_count_bad | w_hi_bad | w_range_bad;
  end

  // -------------------------------------------------------------------------
  // Burst datapath: current word index and the store word for lane k
  // -------------------------------------------------------------------------
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wd_sel;
  logic          w_last;
  logic          w_mem_we;

  always_comb begin
    w_idx    = r_base + {{(AW-3){1'b0}}, r_k};
    w_last   = (r_k == (r_count - 3'd1));
    w_wd_sel = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (r_k == 3'(i)) begin
        w_wd_sel = r_wd[i];
      end
    end
    // Reset must stop a store burst on the very edge it is sampled.
    w_mem_we = !reset && (r_state == StAccess) && r_we;
  end

  // -------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    ready     = 1'b0;
    ack       = 1'b0;
    unique case (r_state)
      StIdle: begin
        ready = 1'b1;
        if (req) begin
          w_state_d = w_req_err ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (w_last) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        ack       = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM state register and burst control
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_base  <= '0;
      r_count <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < MAX_WORDS; i++) begin
        r_wd[i] <= '0;
        r_rd[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          if (req) begin
            r_we    <= we;
            r_base  <= addr[AW+1:2];
            r_count <= count;
            r_k     <= '0;
            r_err   <= w_req_err;
            for (int i = 0; i < MAX_WORDS; i++) begin
              r_wd[i] <= w_wd_in[i];
              r_rd[i] <= '0;
            end
          end
        end
        StAccess: begin
          if (!r_we) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
              if (r_k == 3'(i)) begin
                r_rd[i] <= r_mem[w_idx];
              end
            end
          end
          r_k <= r_k + 3'd1;
        end
        StDone: begin
          // err only qualifies the ack cycle.
          r_err <= 1'b0;
        end
        default: begin
          r_err <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RAM: contents are not reset
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_wd_sel;
    end
  end

  assign err = r_err;
  assign rd1 = r_rd[0];
  assign rd2 = r_rd[1];
  assign rd3 = r_rd[2];
  assign rd4 = r_rd[3];
  assign rd5 = r_rd[4];

endmodule

// File: tb/tb_vmem_responder.sv
module tb_vmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  count;
  logic [31:0] wd1, wd2, wd3, wd4, wd5;
  logic        ready, ack, err;
  logic [31:0] rd1, rd2, rd3, rd4, rd5;

  always #5 clk = ~clk;

  vmem_responder #(
    .DEPTH    (64),
    .MAX_WORDS(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .we   (we),
    .addr (addr),
    .count(count),
    .wd1  (wd1),
    .wd2  (wd2),
    .wd3  (wd3),
    .wd4  (wd4),
    .wd5  (wd5),
    .ready(ready),
    .ack  (ack),
    .err  (err),
    .rd1  (rd1),
    .rd2  (rd2),
    .rd3  (rd3),
    .rd4  (rd4),
    .rd5  (rd5)
  );

  logic [4:0][31:0] w_rd;
  assign w_rd = {rd5, rd4, rd3, rd2, rd1};

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string            name;
    logic             we;
    logic [31:0]      addr;
    logic [2:0]       cnt;
    logic [4:0][31:0] wd;
    logic             exp_err;
    logic [4:0][31:0] exp_rd;
  } vec_t;

  typedef struct {
    string            name;
    logic             err;
    int               lat;
    logic [4:0][31:0] rd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  function automatic logic [4:0][31:0] lanes(input logic [31:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                              input logic [2:0] c, input logic [4:0][31:0] d,
                              input logic e, input logic [4:0][31:0] r);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.cnt = c; v.wd = d; v.exp_err = e; v.exp_rd = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request through the handshake. Expected result goes into the
  // scoreboard when driven and is popped when the DUT raises ack.
  task automatic run_req(input vec_t v);
    exp_t e;
    int   lat;
    int   low;
    bit   got;
    e.name = v.name;
    e.err  = v.exp_err;
    e.lat  = v.exp_err ? 1 : int'(v.cnt) + 1;
    e.rd   = v.exp_rd;
    @(negedge clk);
    chk({v.name, " ready_before"}, {31'b0, ready}, 32'd1);
    req = 1'b1; we = v.we; addr = v.addr; count = v.cnt;
    {wd5, wd4, wd3, wd2, wd1} = v.wd;
    sb_q.push_back(e);
    got = 1'b0;
    low = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req = 1'b0;
      lat = i;
      if (!ready) low++;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    e = sb_q.pop_front();
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s ack_timeout: got no ack expected ack within 20 cycles", e.name);
    end else begin
      chk({e.name, " ack_latency"}, 32'(lat), 32'(e.lat));
      chk({e.name, " ready_low"}, 32'(low), 32'(e.lat));
      chk({e.name, " err"}, {31'b0, err}, {31'b0, e.err});
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("%s rd%0d", e.name, i + 1), w_rd[i], e.rd[i]);
      end
      @(negedge clk);
      chk({e.name, " ack_pulse"}, {31'b0, ack}, 32'd0);
      chk({e.name, " err_clear"}, {31'b0, err}, 32'd0);
      chk({e.name, " ready_after"}, {31'b0, ready}, 32'd1);
      chk({e.name, " rd1_hold"}, rd1, e.rd[0]);
    end
  endtask

  logic [4:0][31:0] z;
  int acks;

  initial begin
    z = '0;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; count = '0;
    wd1 = '0; wd2 = '0; wd3 = '0; wd4 = '0; wd5 = '0;

    tbl.push_back(mk("st10", 1, 32'h10, 1, lanes(32'hDEADBEEF, 0, 0, 0, 0), 0, z));
    tbl.push_back(mk("ld10", 0, 32'h10, 1, z, 0, lanes(32'hDEADBEEF, 0, 0, 0, 0)));
    tbl.push_back(mk("st20x5", 1, 32'h20, 5, lanes(1, 2, 3, 4, 5), 0, z));
    tbl.push_back(mk("ld20x5", 0, 32'h20, 5, z, 0, lanes(1, 2, 3, 4, 5)));
    tbl.push_back(mk("ld24x3", 0, 32'h24, 3, z, 0, lanes(2, 3, 4, 0, 0)));
    tbl.push_back(mk("e_misal", 1, 32'h22, 1, lanes(32'h11, 0, 0, 0, 0), 1, z));
    tbl.push_back(mk("e_cnt0", 1, 32'h20, 0, lanes(32'h22, 0, 0, 0, 0), 1, z));
    tbl.push_back(mk("e_cnt6", 1, 32'h20, 6, lanes(9, 9, 9, 9, 9), 1, z));
    tbl.push_back(mk("e_range", 1, 32'hF4, 4, lanes(7, 7, 7, 7, 7), 1, z));
    tbl.push_back(mk("e_hibit", 1, 32'h1020, 1, lanes(32'h33, 0, 0, 0, 0), 1, z));
    tbl.push_back(mk("ld20_chk", 0, 32'h20, 5, z, 0, lanes(1, 2, 3, 4, 5)));
    tbl.push_back(mk("stF0x4", 1, 32'hF0, 4, lanes(32'hA, 32'hB, 32'hC, 32'hD, 0), 0, z));
    tbl.push_back(mk("ldF0x4", 0, 32'hF0, 4, z, 0, lanes(32'hA, 32'hB, 32'hC, 32'hD, 0)));
    tbl.push_back(mk("ld10_chk", 0, 32'h10, 1, z, 0, lanes(32'hDEADBEEF, 0, 0, 0, 0)));

    // Reset then idle
    repeat (2) @(negedge clk);
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst ack", {31'b0, ack}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    for (int i = 0; i < 5; i++) chk($sformatf("rst rd%0d", i + 1), w_rd[i], 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) run_req(tbl[i]);

    // req pulsed while busy is ignored
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h60; count = 3'd3;
    {wd5, wd4, wd3, wd2, wd1} = lanes(32'h61, 32'h62, 32'h63, 0, 0);
    acks = 0;
    @(negedge clk);
    if (ack) acks++;
    chk("busy ready_low", {31'b0, ready}, 32'd0);
    we = 1'b0; addr = 32'h20; count = 3'd5;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    chk("busy ack_count", 32'(acks), 32'd1);
    chk("busy rd1", rd1, 32'd0);
    run_req(mk("ld60x3", 0, 32'h60, 3, z, 0, lanes(32'h61, 32'h62, 32'h63, 0, 0)));

    // Reset in the middle of a store burst
    run_req(mk("st40_a", 1, 32'h40, 5, lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4), 0, z));
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; count = 3'd5;
    {wd5, wd4, wd3, wd2, wd1} = lanes(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst busy", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst ready", {31'b0, ready}, 32'd1);
    chk("midrst ack", {31'b0, ack}, 32'd0);
    chk("midrst err", {31'b0, err}, 32'd0);
    reset = 1'b0;
    run_req(mk("ld40_mid", 0, 32'h40, 5, z, 0,
               lanes(32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hA4)));

    // Reset and req together: reset wins
    @(negedge clk);
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h40; count = 3'd1;
    {wd5, wd4, wd3, wd2, wd1} = lanes(32'hCC, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstreq ready", {31'b0, ready}, 32'd1);
    reset = 1'b0; req = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("rstreq ack_count", 32'(acks), 32'd0);
    run_req(mk("ld40_rr", 0, 32'h40, 1, z, 0, lanes(32'hB0, 0, 0, 0, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/vmem_responder.md
Name: vmem_responder

Overview:
- Data-memory responder that serves the datapath's vector and scalar load/store requests.
- Holds a word-addressed RAM and services a burst of 1..5 consecutive words, one word per clock.
- Read results return on five lanes that line up with the five vector-ALU result lanes.
- A ready/ack handshake lets the control unit stall the datapath while a burst is in flight.

Parameters:
DEPTH, 64, number of 32-bit words in the RAM (power of two).
MAX_WORDS, 5, maximum burst length; fixed to the number of vector lanes.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req  input  1  request valid; sampled only when ready=1.
we  input  1  1=store burst, 0=load burst; captured with req.
addr  input  32  byte address of word 0 (the ALUResult of the issuing instruction).
count  input  3  burst length in words, legal 1..5.
wd1..wd5  input  32 each  store data for words 0..4; captured with req.
ready  output  1  high only in IDLE.
ack  output  1  one-cycle completion pulse.
err  output  1  qualifies ack; request rejected.
rd1..rd5  output  32 each  load data for words 0..4.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- States: IDLE, ACCESS, DONE.
- Reset: state=IDLE, ready=1, ack=0, err=0, rd1..rd5=0. RAM contents are not reset.
- Reset mid-burst: abort to IDLE with the reset values above. Words already stored stay stored; no further writes occur.
- Accept: happens on a rising edge with state=IDLE and req=1.
  - Latch we, base=addr[31:2], count and wd1..wd5.
  - Clear rd1..rd5 to 0.
  - Set index k=0.
- Error check at accept; any one of these is an error:
  - addr[1:0]!=0
  - count==0 or count>MAX_WORDS
  - base+count-1 >= DEPTH (no wrap-around)
- On error: go straight to DONE with err=1. No RAM access; rd lanes stay 0.
- Otherwise: go to ACCESS with err=0.
- ACCESS: one edge per word k.
  - Store: mem[base+k] <= wd(k+1).
  - Load: rd(k+1) <= mem[base+k].
  - k increments each edge; after the edge with k==count-1, go to DONE.
  - Lanes beyond count stay 0.
- DONE: ack=1 and ready=0 for exactly one cycle; next edge goes to IDLE.
  - err stays valid while ack=1 and returns to 0 on the edge that enters IDLE.
- Latency: an accepted legal request of count n raises ack n cycles after the accept edge, and ready is low for n+1 cycles. An error request raises ack 1 cycle after accept.
- rd1..rd5 hold their values after DONE until the next accept.
- req while ready=0: ignored and not queued. The requester must hold req until it observes ready.
- Simultaneous reset and req: reset wins; the request is not accepted.
- Load-after-store to the same address in back-to-back bursts returns the newly stored data. Bursts are strictly serialized, so no bypass is needed.
- Width rules:
  - Address arithmetic is done on log2(DEPTH)+1 bits so the range check cannot overflow.
  - addr[31:2] bits above the index must be 0, otherwise err.

Test Plan:
1. Reset then idle: assert reset 2 cycles -> ready=1, ack=0, err=0, rd1..rd5=0.
2. Scalar store/load: req, we=1, addr=0x10, count=1, wd1=0xDEADBEEF.
   -> ack 1 cycle after accept, err=0.
   Then load addr=0x10, count=1 -> rd1=0xDEADBEEF, rd2..rd5=0.
3. Full vector burst: store addr=0x20, count=5, wd1..wd5=1,2,3,4,5.
   -> ready low 6 cycles, single ack pulse.
   Load same -> rd1..rd5=1..5. Load count=3 from 0x24 -> rd1..rd3=2,3,4, rd4=rd5=0.
4. Error cases -> ack+err 1 cycle after accept, no memory change, rd lanes=0:
   - addr=0x22
   - count=0
   - count=6
   - addr=0xF4 with count=4 (base 61, end 64 >= DEPTH)
5. Busy/ignore and reset mid-burst:
   - Pulse req during ACCESS -> no second ack.
   - Start store of 5 words at 0x40 and assert reset after 2 access edges -> IDLE next cycle.
   - Subsequent load of 5 from 0x40 shows words 0..1 written and words 2..4 unchanged.
